taint_event_monitor: RTL and testbench

TAINT_EVENT_MONITOR -- requirements
Module: taint_event_monitor

---
 rtl/taint_event_monitor.sv | 135 +++++++++++++
 tb/tb_taint_event_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/taint_event_monitor.sv
// Taint event monitor: records sig/sig_t change events, with timestamps, into a FIFO.
// Optional build macro TAINT_NEW_LABEL_FILTER_EN limits RUN captures to newly appearing labels.
module taint_event_monitor #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sig,
  input  logic [TW-1:0]            sig_t,
  input  logic                     arm,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic                     evt_data,
  output logic [TW-1:0]            evt_taint,
  output logic [15:0]              evt_time,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 1 + TW + 16;
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPrime = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [15:0]   ts_q, ts_d;
  logic          prev_sig_q;
  logic [TW-1:0] prev_t_q;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [EW-1:0] mem_q [DEPTH];

  logic arm_start, capture, change, push, pop, full, accept, drop;

  assign arm_start = (state_q == StIdle) && arm;
  // Dropping arm in PRIME/RUN leaves the cycle without a capture.
  assign capture   = (state_q != StIdle) && arm;

`ifdef TAINT_NEW_LABEL_FILTER_EN
  assign change = |(sig_t & ~prev_t_q);
`else
  assign change = (sig != prev_sig_q) || (sig_t != prev_t_q);
`endif

  assign push   = capture && ((state_q == StPrime) || change);
  assign pop    = evt_valid && evt_ready;
  assign full   = (cnt_q == FullCnt);
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:         if (arm) state_d = StPrime;
      StPrime, StRun: state_d = arm ? StRun : StIdle;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    ts_d = ts_q;
    if (arm_start) begin
      ts_d = '0;
    end else if (capture && (ts_q != 16'hFFFF)) begin
      ts_d = ts_q + 16'd1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (arm_start) begin
      ovf_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ts_q       <= '0;
      prev_sig_q <= 1'b0;
      prev_t_q   <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        prev_sig_q <= sig;
        prev_t_q   <= sig_t;
      end
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (accept) begin
      mem_q[wr_ptr_q] <= {sig, sig_t, ts_q};
    end
  end

  assign evt_valid = (cnt_q != '0);
  assign overflow  = ovf_q;
  assign count     = cnt_q;

  always_comb begin
    {evt_data, evt_taint, evt_time} = '0;
    if (evt_valid) {evt_data, evt_taint, evt_time} = mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_taint_event_monitor.sv
// Directed bench for taint_event_monitor: vector table plus hand-written corner sequences.
module tb_taint_event_monitor;

  logic        clk = 1'b0;
  logic        rst, sig, arm, evt_ready;
  logic [31:0] sig_t;
  logic        evt_valid, evt_data, overflow;
  logic [31:0] evt_taint;
  logic [15:0] evt_time;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;
  logic [48:0] popped[$];

  taint_event_monitor #(.DEPTH(8), .TW(32)) dut (
    .clk(clk), .rst(rst), .sig(sig), .sig_t(sig_t), .arm(arm),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_taint(evt_taint), .evt_time(evt_time), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        arm;
    logic        sig;
    logic [31:0] t;
    logic        rdy;
    logic        vld;
    logic [3:0]  cnt;
    logic        d;
    logic [31:0] taint;
    logic [15:0] tm;
    logic        ovf;
  } vec_t;

  vec_t tv[25];

  function automatic vec_t mk(logic a, logic s, logic [31:0] t, logic r, logic v,
                              logic [3:0] c, logic d, logic [31:0] et, logic [15:0] tm,
                              logic o);
    vec_t x;
    x.arm = a; x.sig = s; x.t = t; x.rdy = r; x.vld = v;
    x.cnt = c; x.d = d; x.taint = et; x.tm = tm; x.ovf = o;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] c,
                         input logic d, input logic [31:0] et, input logic [15:0] tm,
                         input logic o);
    chk({tag, ".valid"}, 64'(evt_valid), 64'(v));
    chk({tag, ".count"}, 64'(count), 64'(c));
    chk({tag, ".data"}, 64'(evt_data), 64'(d));
    chk({tag, ".taint"}, 64'(evt_taint), 64'(et));
    chk({tag, ".time"}, 64'(evt_time), 64'(tm));
    chk({tag, ".ovf"}, 64'(overflow), 64'(o));
  endtask

  // One clock: log a pop that will happen at this edge, then settle past the edge.
  task automatic cyc();
    @(negedge clk);
    if (evt_valid && evt_ready) popped.push_back({evt_data, evt_taint, evt_time});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; sig = 1'b0; sig_t = '0; evt_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // Single-event capture, then overflow, re-arm, and full-FIFO streaming.
    tv[0]  = mk(1, 0, 32'h1,    1, 0, 0, 0, 32'h0,  0, 0);
    tv[1]  = mk(1, 0, 32'h1,    1, 1, 1, 0, 32'h1,  0, 0);
    tv[2]  = mk(1, 0, 32'h1,    1, 0, 0, 0, 32'h0,  0, 0);
    tv[3]  = mk(1, 0, 32'h1,    1, 0, 0, 0, 32'h0,  0, 0);
    tv[4]  = mk(1, 0, 32'h1,    1, 0, 0, 0, 32'h0,  0, 0);
    tv[5]  = mk(0, 0, 32'h1,    1, 0, 0, 0, 32'h0,  0, 0);
    tv[6]  = mk(1, 0, 32'h0,    0, 0, 0, 0, 32'h0,  0, 0);
    tv[7]  = mk(1, 0, 32'h0,    0, 1, 1, 0, 32'h0,  0, 0);
    tv[8]  = mk(1, 1, 32'h1,    0, 1, 2, 0, 32'h0,  0, 0);
    tv[9]  = mk(1, 0, 32'h3,    0, 1, 3, 0, 32'h0,  0, 0);
    tv[10] = mk(1, 1, 32'h7,    0, 1, 4, 0, 32'h0,  0, 0);
    tv[11] = mk(1, 0, 32'hF,    0, 1, 5, 0, 32'h0,  0, 0);
    tv[12] = mk(1, 1, 32'h1F,   0, 1, 6, 0, 32'h0,  0, 0);
    tv[13] = mk(1, 0, 32'h3F,   0, 1, 7, 0, 32'h0,  0, 0);
    tv[14] = mk(1, 1, 32'h7F,   0, 1, 8, 0, 32'h0,  0, 0);
    tv[15] = mk(1, 0, 32'hFF,   0, 1, 8, 0, 32'h0,  0, 1);
    tv[16] = mk(1, 1, 32'h1FF,  0, 1, 8, 0, 32'h0,  0, 1);
    tv[17] = mk(0, 0, 32'h1FF,  0, 1, 8, 0, 32'h0,  0, 1);
    tv[18] = mk(1, 0, 32'h1FF,  0, 1, 8, 0, 32'h0,  0, 0);
    tv[19] = mk(1, 0, 32'h1FF,  1, 1, 8, 1, 32'h1,  1, 0);
    tv[20] = mk(1, 1, 32'h3FF,  1, 1, 8, 0, 32'h3,  2, 0);
    tv[21] = mk(1, 0, 32'h7FF,  1, 1, 8, 1, 32'h7,  3, 0);
    tv[22] = mk(1, 1, 32'hFFF,  1, 1, 8, 0, 32'hF,  4, 0);
    tv[23] = mk(1, 0, 32'h1FFF, 1, 1, 8, 1, 32'h1F, 5, 0);
    tv[24] = mk(1, 1, 32'h3FFF, 1, 1, 8, 0, 32'h3F, 6, 0);

    rst = 1'b1; arm = 1'b1; sig = 1'b1; sig_t = '1; evt_ready = 1'b1;
    cyc();
    cyc();
    chk_out("reset", 0, 0, 0, 32'h0, 16'h0, 0);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      arm = tv[i].arm; sig = tv[i].sig; sig_t = tv[i].t; evt_ready = tv[i].rdy;
      cyc();
      chk_out($sformatf("vec%0d", i), tv[i].vld, tv[i].cnt, tv[i].d, tv[i].taint,
              tv[i].tm, tv[i].ovf);
    end

    // Change detection: taint 1 -> 3 at time 2, then 3 -> 2 at time 4.
    do_reset();
    popped.delete();
    arm = 1'b1; evt_ready = 1'b1;
    begin
      logic [31:0] seq [9];
      seq = '{32'h1, 32'h1, 32'h1, 32'h3, 32'h3, 32'h2, 32'h2, 32'h2, 32'h2};
      for (int i = 0; i < 9; i++) begin
        sig_t = seq[i];
        cyc();
      end
    end
    cyc();
    cyc();
`ifdef TAINT_NEW_LABEL_FILTER_EN
    chk("chg.num_events", 64'(popped.size()), 64'd2);
`else
    chk("chg.num_events", 64'(popped.size()), 64'd3);
`endif
    if (popped.size() >= 2) begin
      chk("chg.ev0", 64'(popped[0]), 64'({1'b0, 32'h1, 16'd0}));
      chk("chg.ev1", 64'(popped[1]), 64'({1'b0, 32'h3, 16'd2}));
    end
`ifndef TAINT_NEW_LABEL_FILTER_EN
    if (popped.size() >= 3) chk("chg.ev2", 64'(popped[2]), 64'({1'b0, 32'h2, 16'd4}));
`endif

    // Mid-capture reset with five stored events.
    do_reset();
    arm = 1'b1; sig = 1'b0; sig_t = '0; evt_ready = 1'b0;
    cyc();
    cyc();
    for (int i = 1; i <= 4; i++) begin
      sig_t = (32'h1 << i) - 32'h1;
      cyc();
    end
    chk("rstmid.count_before", 64'(count), 64'd5);
    #2 rst = 1'b1;
    #1 chk("rstmid.async_count", 64'(count), 64'd0);
    arm = 1'b0;
    cyc();
    chk_out("rstmid.held", 0, 0, 0, 32'h0, 16'h0, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sig = ~sig; sig_t = sig_t + 32'h10;
      cyc();
      chk($sformatf("rstmid.idle%0d.count", i), 64'(count), 64'd0);
    end

    // Re-arm; pop and push together while count=1 keeps valid high.
    arm = 1'b1; sig = 1'b0; sig_t = '0; evt_ready = 1'b1;
    cyc();
    chk("rearm.prime.count", 64'(count), 64'd0);
    cyc();
    chk_out("rearm.baseline", 1, 1, 0, 32'h0, 16'd0, 0);
    sig_t = 32'h1;
    cyc();
    chk_out("rearm.popush", 1, 1, 0, 32'h1, 16'd1, 0);
    sig_t = 32'h1;
    cyc();
    chk("rearm.drained.valid", 64'(evt_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
